seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed seven-segment scanner for the nine-digit rotating display. It reads the nine 5-bit digit codes produced by the digit rotation register and lights one digit at a time, with active-low anode and cathode drives and a dead-time blanking interval between digits. It also generates the scroll-step pulse that paces the rotation register, so scroll speed is an integer number of complete refresh frames.

## Interface
- PRESCALE, default 100000: clock cycles per digit slot; must be at least 2.
- BLANK_CYCLES, default 16: dead-time cycles at the start of each slot with all anodes off; must be less than PRESCALE.
- SCROLL_FRAMES, default 60: completed frames per `step` pulse; must be at least 1.
- clock, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- d1..d9, input, 5 each: digit codes.
  - 0x00–0x0F show a hex glyph.
  - Any code with bit 4 = 1 (nominally 0x10) is blank.
  - d1 is shown on anode bit 0, d9 on anode bit 8.
- scroll_en, input, 1: enables frame counting toward `step`.
- an, output, 9: anode select, active-low, at most one bit low.
- seg, output, 7: cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- step, output, 1: one-cycle scroll pulse, intended as the shifter's clock enable.
- frame_start, output, 1: one-cycle pulse on the first cycle of each frame.

## Operation
- **Counters**
  - Slot counter `cnt` runs 0..PRESCALE-1 and wraps.
  - Digit index `idx` advances 0..8 when `cnt` wraps; 8 wraps to 0.
  - One frame is 9*PRESCALE cycles.
- **Shadow capture**
  - On the edge where `idx` goes 8→0, all nine inputs are captured into shadow registers.
  - The display reads only the shadow, so an input change mid-frame never tears the frame.
  - Shadow resets to 0x10 (blank), so the first frame after reset is dark.
- **Drive**
  - While `cnt` < BLANK_CYCLES, `an` = 9'h1FF and `seg` = 7'h7F.
  - Otherwise, `an` has only bit `idx` low, and `seg` is the decode of shadow[idx].
- **Decode, active-low gfedcba**
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Bit 4 set gives 7F.
- **Frame and step**
  - `frame_start` pulses in the cycle in which `idx` = 0 and `cnt` = 0.
  - Frame counter `fc` runs 0..SCROLL_FRAMES-1 and increments at each 8→0 transition while `scroll_en` = 1.
  - When `fc` = SCROLL_FRAMES-1 at that transition, `fc` goes to 0 and `step` pulses high for one cycle.
  - With `scroll_en` = 0, `fc` holds and `step` stays 0.

## Timing
- **Reset** (reset = 0, immediate, asynchronous):
  - `cnt` = 0, `idx` = 0, `fc` = 0, shadow all 0x10.
  - `an` = 9'h1FF, `seg` = 7'h7F, `step` = 0, `frame_start` = 0.
- **Registered outputs**
  - `an`, `seg`, `step` and `frame_start` are all registered.
  - Each reflects the (`cnt`, `idx`, shadow, `fc`) values present before the same edge, i.e. one cycle of latency.
- **Captured values**
  - Inputs sampled at the 8→0 edge first appear on `seg` at slot 0 of the new frame, after blanking: `idx` = 0, `cnt` = BLANK_CYCLES, plus one cycle of latency.
- **Reset mid-frame**: everything returns to reset values at once. Scan restarts at `idx` 0 on the first edge after release.
- **BLANK_CYCLES = 0**: no dead time; anodes switch directly between neighbouring digits.
- **SCROLL_FRAMES = 1**: `step` pulses at every frame wrap while `scroll_en` = 1.

## Test plan
All scenarios use PRESCALE = 8, BLANK_CYCLES = 2, SCROLL_FRAMES = 2.

- **Reset and first frame**: hold reset low, then release with d1..d9 = 0..8. Throughout the first 72 cycles, `an` = 1FF or one-hot-low and `seg` = 7F (shadow blank). From cycle 72 + 2 + 1, `an` = 1FE and `seg` = 40.
- **Full decode**: run 16 frames, with d1 stepping 0x0..0xF, one value per frame. Each frame's slot-0 `seg` matches the decode list. d1 = 0x10 and 0x1F both give 7F.
- **Blanking and slot order**: over one frame, each slot shows `an` = 1FF for 2 cycles, then a low bit for 6 cycles. The low bit walks 0..8, then wraps to bit 0.
- **No tearing**: change d5 from 3 to 7 while `idx` = 2. The rest of that frame still shows `seg` 30 on bit 4. The next frame shows 78.
- **Step cadence**: with `scroll_en` = 1, `step` pulses once every 144 cycles, aligned with every second `frame_start`. With `scroll_en` held low for 3 frames, `step` = 0 and the cadence phase is preserved.
- **Async reset mid-slot**: assert reset at `idx` = 5, `cnt` = 4. `an` = 1FF and `seg` = 7F without waiting for a clock edge. After release, the scan restarts at slot 0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Nine-digit multiplexed seven-segment scanner with dead-time blanking,
// frame-coherent shadow capture and a frame-paced scroll step pulse.
module seg_scan_driver #(
  parameter int PRESCALE      = 100000,
  parameter int BLANK_CYCLES  = 16,
  parameter int SCROLL_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] d1,
  input  logic [4:0] d2,
  input  logic [4:0] d3,
  input  logic [4:0] d4,
  input  logic [4:0] d5,
  input  logic [4:0] d6,
  input  logic [4:0] d7,
  input  logic [4:0] d8,
  input  logic [4:0] d9,
  input  logic       scroll_en,
  output logic [8:0] an,
  output logic [6:0] seg,
  output logic       step,
  output logic       frame_start
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [FW-1:0] FC_LAST  = FW'(SCROLL_FRAMES - 1);
  localparam logic [4:0]    BLANK_CODE = 5'h10;

  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [FW-1:0] fc;
  logic [4:0]    shadow [9];

  logic       slot_end;
  logic       frame_end;
  logic       blanking;
  logic [4:0] cur_code;
  logic [6:0] cur_glyph;

  // Slot / frame boundary and dead-time qualifiers
  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == 4'd8);
    blanking  = (int'(cnt) < BLANK_CYCLES);
    cur_code  = shadow[idx];
  end

  // Active-low gfedcba glyph for the digit in the current slot
  always_comb begin
    cur_glyph = 7'h7F;
    if (!cur_code[4]) begin
      unique case (cur_code[3:0])
        4'h0: cur_glyph = 7'h40;
        4'h1: cur_glyph = 7'h79;
        4'h2: cur_glyph = 7'h24;
        4'h3: cur_glyph = 7'h30;
        4'h4: cur_glyph = 7'h19;
        4'h5: cur_glyph = 7'h12;
        4'h6: cur_glyph = 7'h02;
        4'h7: cur_glyph = 7'h78;
        4'h8: cur_glyph = 7'h00;
        4'h9: cur_glyph = 7'h10;
        4'hA: cur_glyph = 7'h08;
        4'hB: cur_glyph = 7'h03;
        4'hC: cur_glyph = 7'h46;
        4'hD: cur_glyph = 7'h21;
        4'hE: cur_glyph = 7'h06;
        4'hF: cur_glyph = 7'h0E;
        default: cur_glyph = 7'h7F;
      endcase
    end
  end

  // Slot counter and digit index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Whole-frame snapshot of the digit codes, taken at the frame wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) shadow[i] <= BLANK_CODE;
    end else if (frame_end) begin
      shadow[0] <= d1;
      shadow[1] <= d2;
      shadow[2] <= d3;
      shadow[3] <= d4;
      shadow[4] <= d5;
      shadow[5] <= d6;
      shadow[6] <= d7;
      shadow[7] <= d8;
      shadow[8] <= d9;
    end
  end

  // Frame counter and scroll step pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fc   <= '0;
      step <= 1'b0;
    end else begin
      step <= frame_end && scroll_en && (fc == FC_LAST);
      if (frame_end && scroll_en)
        fc <= (fc == FC_LAST) ? '0 : fc + FW'(1);
    end
  end

  // Registered anode / cathode drive and frame marker
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an          <= 9'h1FF;
      seg         <= 7'h7F;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (cnt == '0) && (idx == 4'd0);
      if (blanking) begin
        an  <= 9'h1FF;
        seg <= 7'h7F;
      end else begin
        an  <= ~(9'h001 << idx);
        seg <= cur_glyph;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with PRESCALE=8, BLANK_CYCLES=2,
// SCROLL_FRAMES=2; edges are counted from reset release.
module tb_seg_scan_driver;

  logic       clock;
  logic       reset;
  logic [4:0] d [9];
  logic       scroll_en;
  logic [8:0] an;
  logic [6:0] seg;
  logic       step;
  logic       frame_start;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  seg_scan_driver #(
    .PRESCALE(8),
    .BLANK_CYCLES(2),
    .SCROLL_FRAMES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .d1(d[0]),
    .d2(d[1]),
    .d3(d[2]),
    .d4(d[3]),
    .d5(d[4]),
    .d6(d[5]),
    .d7(d[6]),
    .d8(d[7]),
    .d9(d[8]),
    .scroll_en(scroll_en),
    .an(an),
    .seg(seg),
    .step(step),
    .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge reset)
    if (!reset) edges <= 0;
    else edges <= edges + 1;

  function automatic logic [6:0] dec(input logic [4:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    if (v[4]) return 7'h7F;
    return t[v[3:0]];
  endfunction

  function automatic logic [8:0] exp_an(input int k);
    logic [8:0] r;
    int c, i;
    c = (k - 1) % 8;
    i = ((k - 1) / 8) % 9;
    r = 9'h1FF;
    if (c >= 2) r[i] = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic go(input int k);
    int guard;
    guard = 0;
    while (edges < k && guard < 5000) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (edges < k) begin
      errors++;
      $error("FAIL timeout edges=%0d exp=%0d", edges, k);
    end
  endtask

  initial begin
    int e0;
    int c, i;
    logic [4:0] v;
    reset = 1'b0;
    scroll_en = 1'b0;
    for (int j = 0; j < 9; j++) d[j] = 5'(j);
    #12;
    chk("rst_an", 32'(an), 32'h1FF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // first frame dark, then d1..d9 = 0..8 appear
    for (int k = 1; k <= 80; k++) begin
      go(k);
      c = (k - 1) % 8;
      i = ((k - 1) / 8) % 9;
      chk("f1_an", 32'(an), 32'(exp_an(k)));
      chk("f1_seg", 32'(seg),
          32'((k <= 72 || c < 2) ? 7'h7F : dec(5'(i))));
      chk("f1_fs", 32'(frame_start), 32'((k - 1) % 72 == 0));
      chk("f1_step", 32'(step), 32'h0);
    end

    // one d1 value per frame, checked at slot 0 after blanking
    for (int f = 1; f <= 17; f++) begin
      v = (f <= 15) ? 5'(f) : ((f == 16) ? 5'h10 : 5'h1F);
      d[0] = v;
      go(72 * (f + 1) + 3);
      chk("dec_seg", 32'(seg), 32'(dec(v)));
      chk("dec_an", 32'(an), 32'h1FE);
    end
    d[0] = 5'h0;

    // d5 changes mid-frame: no tearing
    d[4] = 5'h3;
    go(1368 + 18);
    d[4] = 5'h7;
    go(1368 + 35);
    chk("tear_an", 32'(an), 32'h1EF);
    chk("tear_seg", 32'(seg), 32'h30);
    go(1440 + 35);
    chk("tear_an2", 32'(an), 32'h1EF);
    chk("tear_seg2", 32'(seg), 32'h78);

    // step cadence with scroll enabled
    e0 = 1512;
    go(e0);
    scroll_en = 1'b1;
    for (int k = e0 + 1; k <= e0 + 288; k++) begin
      go(k);
      chk("step_on", 32'(step), 32'((k - e0) % 144 == 0));
      chk("fs_on", 32'(frame_start), 32'((k - 1) % 72 == 0));
    end
    scroll_en = 1'b0;
    for (int k = e0 + 289; k <= e0 + 504; k++) begin
      go(k);
      chk("step_off", 32'(step), 32'h0);
    end
    scroll_en = 1'b1;
    for (int k = e0 + 505; k <= e0 + 648; k++) begin
      go(k);
      chk("step_phase", 32'(step), 32'(k == e0 + 648));
    end

    // async reset at idx 5, cnt 4
    go(2204);
    chk("pre_an", 32'(an), 32'h1DF);
    chk("pre_seg", 32'(seg), 32'h12);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_an", 32'(an), 32'h1FF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_step", 32'(step), 32'h0);
    chk("arst_fs", 32'(frame_start), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      go(k);
      chk("rs_an", 32'(an), 32'(exp_an(k)));
      chk("rs_seg", 32'(seg), 32'h7F);
      chk("rs_fs", 32'(frame_start), 32'(k == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
